// File: rtl/updown_seq_checker.sv
// updown_seq_checker
//   Watches the output of a bouncing up/down counter (0..MAX..0..) and checks that
//   every enabled sample steps by exactly +1/-1, reversing only at MAX and 0.
//
// Parameters
//   MAX        top value of the bouncing sequence (2..31)
//   WIDTH      width of count_in
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   enable       sample strobe; count_in is evaluated only when high
//   count_in     observed counter value
//   locked       high while tracking (UP or DOWN)
//   dir          0 = ascending, 1 = descending; 0 when not locked
//   at_peak      one-cycle pulse: accepted sample equal to MAX
//   at_trough    one-cycle pulse: accepted sample equal to 0
//   err          one-cycle pulse: sample violated the expected sequence
//   sweep_count  peaks seen since reset, modulo 256
//   err_count    saturating count of err pulses
//
// Build option
//   UPDOWN_SEQ_CHECKER_ERRCNT_EN  when defined, err_count is a saturating counter;
//                                 otherwise err_count is tied to 0.
module updown_seq_checker #(
    parameter int unsigned MAX   = 15,
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             dir,
    output logic             at_peak,
    output logic             at_trough,
    output logic             err,
    output logic [7:0]       sweep_count,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {StHunt, StSync, StUp, StDown} state_e;

    // One extra bit so prev+1 and the range check cannot overflow.
    localparam logic [WIDTH:0] MaxVal = (WIDTH + 1)'(MAX);
    localparam logic [WIDTH:0] One    = (WIDTH + 1)'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    logic       locked_q, locked_d;
    logic       dir_q, dir_d;
    logic       peak_q, peak_d;
    logic       trough_q, trough_d;
    logic       err_q, err_d;
    logic [7:0] sweep_q, sweep_d;

    logic [WIDTH:0] sample_w, prev_w;
    logic           out_of_range, is_max, is_zero, step_up, step_down;

    assign sample_w     = {1'b0, count_in};
    assign prev_w       = {1'b0, prev_q};
    assign out_of_range = sample_w > MaxVal;
    assign is_max       = sample_w == MaxVal;
    assign is_zero      = count_in == '0;
    assign step_up      = sample_w == prev_w + One;
    // prev=0 has no predecessor; without this guard 0-1 would never match anyway,
    // but it keeps the intent explicit.
    assign step_down    = (prev_q != '0) && (sample_w == prev_w - One);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StHunt;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
        end
    end

    // Next-state logic; also classifies the sample into peak/trough/error events.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        peak_d   = 1'b0;
        trough_d = 1'b0;
        err_d    = 1'b0;
        if (enable) begin
            if (out_of_range) begin
                err_d   = 1'b1;
                state_d = StHunt;
            end else begin
                prev_d = count_in;
                unique case (state_q)
                    StHunt: state_d = StSync;
                    StSync: begin
                        if (step_up) begin
                            peak_d  = is_max;
                            state_d = is_max ? StDown : StUp;
                        end else if (step_down) begin
                            trough_d = is_zero;
                            state_d  = is_zero ? StUp : StDown;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    StUp: begin
                        if (step_up) begin
                            peak_d  = is_max;
                            state_d = is_max ? StDown : StUp;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StSync;
                        end
                    end
                    StDown: begin
                        if (step_down) begin
                            trough_d = is_zero;
                            state_d  = is_zero ? StUp : StDown;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StSync;
                        end
                    end
                    default: state_d = StHunt;
                endcase
            end
        end
    end

    // Output next-values, derived from the next state so the registered outputs
    // line up with the state they describe.
    always_comb begin
        locked_d = (state_d == StUp) || (state_d == StDown);
        dir_d    = state_d == StDown;
        sweep_d  = sweep_q + 8'(peak_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_q <= 1'b0;
            dir_q    <= 1'b0;
            peak_q   <= 1'b0;
            trough_q <= 1'b0;
            err_q    <= 1'b0;
            sweep_q  <= '0;
        end else begin
            locked_q <= locked_d;
            dir_q    <= dir_d;
            peak_q   <= peak_d;
            trough_q <= trough_d;
            err_q    <= err_d;
            sweep_q  <= sweep_d;
        end
    end

`ifdef UPDOWN_SEQ_CHECKER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

    assign locked      = locked_q;
    assign dir         = dir_q;
    assign at_peak     = peak_q;
    assign at_trough   = trough_q;
    assign err         = err_q;
    assign sweep_count = sweep_q;

endmodule

// File: doc/updown_seq_checker.md
UPDOWN_SEQ_CHECKER -- requirements
Module: updown_seq_checker

Interface
REQ-001 Parameter MAX, default 15: top value of the bouncing count sequence; legal range 2..31.
REQ-002 Parameter WIDTH, default 5: width of count_in.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  sample strobe; count_in is evaluated only in cycles where enable=1.
REQ-006 count_in  input  WIDTH  observed count value from the up/down counter.
REQ-007 locked  output  1  high while the state is UP or DOWN.
REQ-008 dir  output  1  0 = ascending, 1 = descending; valid while locked=1, else 0.
REQ-009 at_peak  output  1  one-cycle pulse: an accepted sample equals MAX.
REQ-010 at_trough  output  1  one-cycle pulse: an accepted sample equals 0 while locked.
REQ-011 err  output  1  one-cycle pulse: a sample violated the expected sequence.
REQ-012 sweep_count  output  8  number of peaks seen since reset, modulo 256.
REQ-013 err_count  output  8  saturating count of err pulses (see Configuration).

Function
REQ-014 Expected sequence: 0,1,...,MAX,MAX-1,...,0,1,... Each enabled sample shall step by exactly +1 or -1 and reverse only at MAX or 0.
REQ-015 States: HUNT (no reference), SYNC (one reference sample held in prev), UP, DOWN.
REQ-016 HUNT: a sample <= MAX stores prev and goes to SYNC. A sample > MAX pulses err and stays in HUNT.
REQ-017 SYNC, sample = prev+1: go to UP. If the sample equals MAX, pulse at_peak and go to DOWN instead.
REQ-018 SYNC, sample = prev-1: go to DOWN. If the sample equals 0, pulse at_trough and go to UP instead.
REQ-019 SYNC, any other sample <= MAX (including a repeated value): pulse err, store the sample in prev, stay in SYNC.
REQ-020 UP: expect prev+1. On a match equal to MAX, pulse at_peak, increment sweep_count and go to DOWN. On any other match, stay in UP.
REQ-021 DOWN: expect prev-1. On a match equal to 0, pulse at_trough and go to UP. On any other match, stay in DOWN.
REQ-022 UP/DOWN mismatch with sample <= MAX: pulse err, store the sample in prev, go to SYNC (resync).
REQ-023 Any sample > MAX in any state: pulse err and go to HUNT.
REQ-024 Every accepted or resync sample shall update prev.
REQ-025 Cycles with enable=0 change no state and produce no pulses.
REQ-026 All outputs are registered. Pulses assert in the cycle after the sampling edge and last exactly one cycle.
REQ-027 sweep_count wraps from 255 to 0.
REQ-028 A sample of 0 at the trough and a sample of MAX at the peak are each a single sample; there is no dwell.

Reset
REQ-029 While reset=1: state=HUNT, prev=0, locked=0, dir=0, at_peak=0, at_trough=0, err=0, sweep_count=0, err_count=0.
REQ-030 Reset shall take effect immediately and asynchronously, override enable, and abort any in-progress sequence.
REQ-031 The first enabled sample after reset deassertion is handled as in HUNT.

Configuration
REQ-032 Macro UPDOWN_SEQ_CHECKER_ERRCNT_EN defined: err_count increments on each err pulse and saturates at 255.
REQ-033 Macro UPDOWN_SEQ_CHECKER_ERRCNT_EN undefined: err_count is tied to 0 and no counter register is built. All other behaviour is unchanged.

Verification
REQ-034 Reset, then enable=1 with count_in 0,1,2..15,14..0 (MAX=15) -> locked after the 2nd sample; at_peak once after 15; at_trough once after the final 0; sweep_count=1; err never asserts.
REQ-035 Locked UP with prev=7, sample 9 -> err pulse, state SYNC, locked=0; samples 10,11 -> locked=1, dir=0; err_count=1 with macro defined, 0 without.
REQ-036 Sample 20 (> MAX) while locked -> err pulse, state HUNT; next sample 3 -> SYNC, no err.
REQ-037 Sequence ascending to 15 with enable toggling 1/0 every cycle -> identical outputs to REQ-034, delivered only on enabled samples.
REQ-038 Assert reset asynchronously mid-sweep while in DOWN at prev=9 -> all outputs 0 without waiting for a clock edge; after release, sample 9 enters SYNC and does not raise err.
REQ-039 Drive 300 consecutive repeated values with the macro defined -> err pulses each sample after the first; err_count saturates at 255.
